// File: rtl/int_sqrt_pkg.sv
// Shared types and helpers for the sequential integer square-root unit.
package int_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int rw_of(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/int_sqrt_step.sv
// One restoring square-root iteration: appends a two-bit digit to the partial
// remainder and decides the next root bit. Purely combinational.
module int_sqrt_step #(
  parameter int RW = 8
) (
  input  logic [RW+1:0] r,
  input  logic [RW-1:0] q,
  input  logic [1:0]    digit,
  output logic [RW+1:0] r_nxt,
  output logic [RW-1:0] q_nxt
);

  localparam int RW2 = RW + 2;

  logic [RW+3:0] r_sh;
  logic [RW+3:0] t;
  logic          ge;

  // Full-width shift and trial subtrahend so the compare never loses bits.
  always_comb begin
    r_sh  = {r, digit};
    t     = {2'b00, q, 2'b01};
    ge    = (r_sh >= t);
    r_nxt = ge ? RW2'(r_sh - t) : r_sh[RW+1:0];
    q_nxt = {q[RW-2:0], ge};
  end

endmodule

// File: rtl/int_sqrt_seq.sv
// Sequential floor(sqrt(X)) with remainder, one root bit per clock.
// Start/Busy/Done handshake; a new operand may be accepted in the Done cycle.
module int_sqrt_seq
  import int_sqrt_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int RW    = rw_of(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  output logic             Busy,
  output logic             Done,
  output logic [RW-1:0]    Root,
  output logic [RW:0]      Rem
);

  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("int_sqrt_seq: WIDTH must be even and >= 4");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sreg;
  logic [RW+1:0]   r, r_nxt;
  logic [RW-1:0]   q, q_nxt;
  logic            accept;

  int_sqrt_step #(.RW(RW)) u_step (
    .r     (r),
    .q     (q),
    .digit (sreg[WIDTH-1:WIDTH-2]),
    .r_nxt (r_nxt),
    .q_nxt (q_nxt)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = Start;
        if (Start) state_nxt = CALC;
      end
      CALC: begin
        Busy = 1'b1;
        if (cnt == '0) state_nxt = FIN;
      end
      FIN: begin
        Done      = 1'b1;
        accept    = Start;
        state_nxt = Start ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt  <= '0;
      sreg <= '0;
      r    <= '0;
      q    <= '0;
      Root <= '0;
      Rem  <= '0;
    end else if (accept) begin
      cnt  <= CW'(RW - 1);
      sreg <= X;
      r    <= '0;
      q    <= '0;
    end else if (state == CALC) begin
      cnt  <= cnt - 1'b1;
      sreg <= {sreg[WIDTH-3:0], 2'b00};
      r    <= r_nxt;
      q    <= q_nxt;
      // Final remainder is bounded by 2*Root, so it fits in RW+1 bits.
      if (cnt == '0) begin
        Root <= q_nxt;
        Rem  <= r_nxt[RW:0];
      end
    end
  end

endmodule

// File: tb/tb_int_sqrt_seq.sv
// Self-checking bench for int_sqrt_seq at WIDTH=16 and WIDTH=8.
module tb_int_sqrt_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, busy16, done16;
  logic [15:0] x16 = '0;
  logic [7:0]  root16;
  logic [8:0]  rem16;

  logic        start8 = 1'b0, busy8, done8;
  logic [7:0]  x8 = '0;
  logic [3:0]  root8;
  logic [4:0]  rem8;

  int total = 0;
  int bad   = 0;

  int_sqrt_seq #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset(rst_n), .Start(start16), .X(x16),
    .Busy(busy16), .Done(done16), .Root(root16), .Rem(rem16)
  );

  int_sqrt_seq #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset(rst_n), .Start(start8), .X(x8),
    .Busy(busy8), .Done(done8), .Root(root8), .Rem(rem8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: largest k with k*k <= x.
  function automatic int isqrt(input int x);
    int k = 0;
    while ((k + 1) * (k + 1) <= x) k++;
    return k;
  endfunction

  task automatic run_op(input bit w8, input int x, output int root, output int rem,
                        output int cyc, output int bcnt);
    @(negedge clk);
    if (w8) begin start8 = 1'b1; x8 = x[7:0]; end
    else    begin start16 = 1'b1; x16 = x[15:0]; end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    x8 = 8'($urandom); x16 = 16'($urandom);
    cyc = 0; bcnt = 0; root = -1; rem = -1;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (w8 ? busy8 : busy16) bcnt++;
      if (w8 ? done8 : done16) begin
        root = w8 ? int'(root8) : int'(root16);
        rem  = w8 ? int'(rem8)  : int'(rem16);
        break;
      end
    end
  endtask

  task automatic verify(input bit w8, input int x, input string tag);
    int root, rem, cyc, bcnt, er, rw;
    rw = w8 ? 4 : 8;
    run_op(w8, x, root, rem, cyc, bcnt);
    er = isqrt(x);
    check({tag, "_root"}, root, er);
    check({tag, "_rem"}, rem, x - er * er);
    check({tag, "_lat"}, cyc, rw + 1);
    check({tag, "_inv"}, ((root * root + rem == x) && (rem <= 2 * root)) ? 1 : 0, 1);
  endtask

  initial begin
    int root, rem, cyc, bcnt, c, n, first, second, r1, m1, r2, m2;

    #3;
    check("rst_busy16", busy16, 0);
    check("rst_done16", done16, 0);
    check("rst_root16", root16, 0);
    check("rst_rem16", rem16, 0);
    check("rst_done8", done8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // X=144: latency, busy duration, single-cycle Done
    run_op(0, 144, root, rem, cyc, bcnt);
    check("sq144_root", root, 12);
    check("sq144_rem", rem, 0);
    check("sq144_lat", cyc, 9);
    check("sq144_busy", bcnt, 8);
    check("sq144_fin_busy", busy16, 0);
    @(negedge clk);
    check("sq144_done_fall", done16, 0);
    check("sq144_hold_root", root16, 12);

    run_op(0, 0, root, rem, cyc, bcnt);
    check("zero_root", root, 0);
    check("zero_rem", rem, 0);
    run_op(0, 65535, root, rem, cyc, bcnt);
    check("max_root", root, 255);
    check("max_rem", rem, 510);

    // WIDTH=8 back-to-back with Start held through FIN
    @(negedge clk);
    start8 = 1'b1; x8 = 8'd255;
    @(posedge clk); #1;
    x8 = 8'd200;
    c = 0; n = 0; first = 0; second = 0; r1 = 0; m1 = 0; r2 = 0; m2 = 0;
    while (c < 30 && n < 2) begin
      @(negedge clk);
      c++;
      if (done8) begin
        n++;
        if (n == 1) begin
          first = c; r1 = root8; m1 = rem8;
          @(posedge clk); #1;
          start8 = 1'b0;
        end else begin
          second = c; r2 = root8; m2 = rem8;
        end
      end
    end
    start8 = 1'b0;
    check("b2b_count", n, 2);
    check("b2b_root1", r1, 15);
    check("b2b_rem1", m1, 30);
    check("b2b_root2", r2, 14);
    check("b2b_rem2", m2, 4);
    check("b2b_gap", second - first, 5);

    // Start during Busy is ignored
    @(negedge clk);
    start16 = 1'b1; x16 = 16'd1000;
    @(posedge clk); #1;
    start16 = 1'b0; x16 = 16'd0;
    c = 0; n = 0; root = -1; rem = -1;
    while (c < 20) begin
      @(negedge clk);
      c++;
      if (c == 3) begin start16 = 1'b1; x16 = 16'd9; end
      if (c == 4) start16 = 1'b0;
      if (done16) begin n++; root = root16; rem = rem16; end
    end
    check("ign_dones", n, 1);
    check("ign_root", root, 31);
    check("ign_rem", rem, 39);

    // Asynchronous reset mid-computation
    @(negedge clk);
    start16 = 1'b1; x16 = 16'd50000;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy16, 0);
    check("arst_done", done16, 0);
    check("arst_root", root16, 0);
    check("arst_rem", rem16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done16) n++;
    end
    check("arst_no_done", n, 0);
    run_op(0, 50000, root, rem, cyc, bcnt);
    check("post_rst_root", root, 223);
    check("post_rst_rem", rem, 271);

    for (int i = 0; i < 256; i++) verify(1, i, "sweep8");
    for (int i = 0; i < 2000; i++) verify(0, int'($urandom_range(65535, 0)), "rand16");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
